// File: rtl/sched_pkg.sv
// sched_pkg: scheduler/detector state encodings and default word width
package sched_pkg;
    localparam int W_DEF = 8;
    typedef enum logic [2:0] {IDLE, CLR, SHIFT, TAIL, DONE} sched_state_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_state_t;
endpackage

// File: rtl/seq_detector.sv
// seq_detector: 4-state Moore detector (clk, rst async, clr sync with priority, x serial in, y high in S0/S3)
module seq_detector
    import sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic x,
    output logic y
);
    det_state_t s, s_nx;
    always_ff @(posedge clk or posedge rst)
        if (rst) s <= S0;
        else     s <= s_nx;
    always_comb begin
        s_nx = clr ? S0 :
               s == S0 ? (x ? S0 : S1) :
               s == S1 ? (x ? S1 : S2) :
               s == S2 ? (x ? S3 : S0) :
                         (x ? S1 : S2);
        y = (s == S0) || (s == S3);
    end
endmodule

// File: rtl/detector_scheduler.sv
// detector_scheduler: round-robin share of one seq_detector between req0/req1 (valid/ready/data in), result out (res_valid/ready/id/count/last_y), busy
module detector_scheduler
    import sched_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_data,
    output logic          req1_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_id,
    output logic [CW-1:0] res_count,
    output logic          res_last_y,
    output logic          busy
);
    localparam int BW = $clog2(W);
    sched_state_t st, st_nx;
    logic [W-1:0]  sr;
    logic [BW-1:0] bit_i;
    logic          last, gnt1, acc, bit_end, y;
    seq_detector u_det (
        .clk(clk),
        .rst(rst),
        .clr(st == CLR),
        .x  (sr[W-1]),
        .y  (y)
    );
    assign gnt1       = req1_valid && (!req0_valid || !last);
    assign req0_ready = (st == IDLE) && req0_valid && !gnt1;
    assign req1_ready = (st == IDLE) && gnt1;
    assign acc        = req0_ready || req1_ready;
    assign bit_end    = bit_i == BW'(W - 1);
    assign busy       = st != IDLE;
    assign res_valid  = st == DONE;
    always_comb begin
        st_nx = st == IDLE  ? (acc ? CLR : IDLE) :
                st == CLR   ? SHIFT :
                st == SHIFT ? (bit_end ? TAIL : SHIFT) :
                st == TAIL  ? DONE :
                              (res_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            sr         <= '0;
            bit_i      <= '0;
            last       <= 1'b1;
            res_id     <= 1'b0;
            res_count  <= '0;
            res_last_y <= 1'b0;
        end else begin
            st <= st_nx;
            case (st)
                IDLE: if (acc) begin
                    sr     <= gnt1 ? req1_data : req0_data;
                    res_id <= gnt1;
                    last   <= gnt1;
                end
                CLR: begin
                    res_count <= '0;
                    bit_i     <= '0;
                end
                SHIFT: begin
                    sr    <= sr << 1;
                    bit_i <= bit_i + 1'b1;
                    if (bit_i != '0 && y) res_count <= res_count + 1'b1;
                end
                TAIL: begin
                    res_last_y <= y;
                    if (y) res_count <= res_count + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
